// File: rtl/trace_emitter.sv
// trace_emitter
//   Serialises CPU retirement events into the ASCII trace stream, one
//   character per clock. One event is accepted at a time, its cycle time is
//   converted to BCD by a 14-step double dabble, then a complete line is
//   emitted:
//     register write : ^<time>@<pc>: $<reg> <= <data>#
//     memory write   : ^<time>@<pc>: *<addr> <= <data>#
//   Hex fields are always 8 lowercase digits, MSB first. Decimal fields
//   carry no leading zeros.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   in_valid/ready   event handshake; in_ready is high only in IDLE
//   in_is_mem        0 = register write, 1 = memory write
//   in_time          cycle time, clamped to 9999 when latched
//   in_pc/reg/addr/data  event fields
//   out_valid        out_char carries a stream character (registered)
//   out_char         ASCII character, 8'h00 when out_valid=0 (registered)
//   busy             high in CONV and EMIT
//
// Configuration macro
//   TRACE_EMIT_ZERO_FILTER_EN  register events to $0 are accepted and dropped

// One BCD digit of the double dabble: add 3 when the digit is 5 or more so
// the following left shift carries correctly into the next digit.
module trace_emitter_dd_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module trace_emitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_mem,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [7:0]  out_char,
  output logic        busy
);

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  state_t      state, state_nxt;

  logic        is_mem_q;
  logic [13:0] bin_q;
  logic [31:0] pc_q, addr_q, data_q;
  logic [4:0]  reg_q;
  logic [NUM_DIGITS-1:0][3:0] bcd_q, bcd_adj;
  logic [3:0]  cnt_q;
  logic [5:0]  idx_q;

  logic        drop;
  logic [13:0] time_clamped;
  logic [2:0]  nt, nr;
  logic [4:0]  reg_tens, reg_units;
  logic [7:0]  ch;
  logic        last;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  function automatic logic [3:0] nib(input logic [31:0] w, input logic [5:0] k);
    nib = 4'(w >> {k, 2'b00});
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  // Common line tail after the destination field: " <= dddddddd#"
  function automatic logic [7:0] tail_char(input logic [5:0] u, input logic [31:0] d);
    case (u)
      6'd0:    tail_char = " ";
      6'd1:    tail_char = "<";
      6'd2:    tail_char = "=";
      6'd3:    tail_char = " ";
      6'd12:   tail_char = "#";
      default: tail_char = hex_char(nib(d, 6'd11 - u));
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Input qualification
  // ---------------------------------------------------------------------
`ifdef TRACE_EMIT_ZERO_FILTER_EN
  assign drop = !in_is_mem && (in_reg == 5'd0);
`else
  assign drop = 1'b0;
`endif

  assign time_clamped = (in_time > 14'd9999) ? 14'd9999 : in_time;

  // ---------------------------------------------------------------------
  // Double dabble digit correction, one instance per BCD digit
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dd
    trace_emitter_dd_digit u_dig (.d(bcd_q[g]), .q(bcd_adj[g]));
  end

  // ---------------------------------------------------------------------
  // Decimal field widths and register digits
  // ---------------------------------------------------------------------
  always_comb begin
    nt = 3'd1;
    if      (bcd_q[3] != 4'd0) nt = 3'd4;
    else if (bcd_q[2] != 4'd0) nt = 3'd3;
    else if (bcd_q[1] != 4'd0) nt = 3'd2;

    nr = (reg_q >= 5'd10) ? 3'd2 : 3'd1;

    reg_tens  = 5'd0;
    reg_units = reg_q;
    if (reg_q >= 5'd30) begin
      reg_tens  = 5'd3;
      reg_units = reg_q - 5'd30;
    end else if (reg_q >= 5'd20) begin
      reg_tens  = 5'd2;
      reg_units = reg_q - 5'd20;
    end else if (reg_q >= 5'd10) begin
      reg_tens  = 5'd1;
      reg_units = reg_q - 5'd10;
    end
  end

  // ---------------------------------------------------------------------
  // Character generator. idx_q walks the line; r is the offset past the
  // time field, u the offset into the shared " <= data#" tail.
  // ---------------------------------------------------------------------
  always_comb begin
    logic [5:0] r, u;
    logic       use_tail;
    ch       = 8'h00;
    last     = 1'b0;
    r        = 6'd0;
    u        = 6'd0;
    use_tail = 1'b0;
    if (idx_q == 6'd0) begin
      ch = "^";
    end else if (idx_q <= {3'b000, nt}) begin
      // Most significant printed digit sits at nibble nt-1.
      ch = 8'h30 + {4'h0, nib({16'h0000, bcd_q}, {3'b000, nt} - idx_q)};
    end else begin
      r = idx_q - {3'b000, nt} - 6'd1;
      if (r == 6'd0)       ch = "@";
      else if (r <= 6'd8)  ch = hex_char(nib(pc_q, 6'd8 - r));
      else if (r == 6'd9)  ch = ":";
      else if (r == 6'd10) ch = " ";
      else if (!is_mem_q) begin
        if (r == 6'd11) ch = "$";
        else if (r < 6'd12 + {3'b000, nr}) begin
          if (nr == 3'd2 && r == 6'd12) ch = 8'h30 + {3'b000, reg_tens};
          else                          ch = 8'h30 + {3'b000, reg_units};
        end else begin
          u        = r - 6'd12 - {3'b000, nr};
          use_tail = 1'b1;
        end
      end else begin
        if (r == 6'd11)      ch = "*";
        else if (r <= 6'd19) ch = hex_char(nib(addr_q, 6'd19 - r));
        else begin
          u        = r - 6'd20;
          use_tail = 1'b1;
        end
      end
      if (use_tail) begin
        ch   = tail_char(u, data_q);
        last = (u == 6'd12);
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && !drop) state_nxt = CONV;
      end
      CONV: if (cnt_q == 4'd13) state_nxt = EMIT;
      EMIT: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      is_mem_q  <= 1'b0;
      bin_q     <= '0;
      pc_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      reg_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
    end else begin
      out_valid <= (state == EMIT);
      out_char  <= (state == EMIT) ? ch : 8'h00;
      case (state)
        IDLE: if (in_valid && !drop) begin
          is_mem_q <= in_is_mem;
          bin_q    <= time_clamped;
          pc_q     <= in_pc;
          addr_q   <= in_addr;
          data_q   <= in_data;
          reg_q    <= in_reg;
          bcd_q    <= '0;
          cnt_q    <= '0;
          idx_q    <= '0;
        end
        CONV: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + 4'd1;
        end
        EMIT: idx_q <= idx_q + 6'd1;
        default: ;
      endcase
    end
  end

endmodule
